mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum number of REQ-state cycles to wait for dmem_ack (legal range 1..15).
REQ-002 The block SHALL have the following ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_read_r  input  1  the EX/MEM instruction is a load.
- mem_write_r  input  1  the EX/MEM instruction is a store.
- addr_r  input  16  word address, from the EX/MEM ALU result.
- store_data_r  input  16  store data from EX/MEM.
- dmem_req  output  1  data-memory request, registered.
- dmem_we  output  1  1 = write, 0 = read; registered.
- dmem_addr  output  16  latched access address; registered.
- dmem_wdata  output  16  latched store data; registered.
- dmem_rdata  input  16  memory read data; valid only when dmem_ack=1.
- dmem_ack  input  1  memory completion, one-cycle pulse.
- read_data_memory  output  16  load result to the MEM/WB register; registered.
- mem_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM; combinational.
- mem_error  output  1  one-cycle pulse in DONE after a timeout.
- err_sticky  output  1  set by any timeout; cleared only by reset.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, REQ and DONE.
REQ-004 Access is defined as mem_read_r | mem_write_r; when both are 1, the block SHALL treat the access as a write.
REQ-005 IDLE with access=1: mem_stall=1 combinationally in the same cycle; at the next edge the block SHALL latch addr_r and store_data_r into dmem_addr and dmem_wdata, set dmem_we=mem_write_r, set dmem_req=1, clear the timeout counter and go to REQ.
REQ-006 IDLE with access=0: the block SHALL keep mem_stall=0 and dmem_req=0, and SHALL not start a transaction.
REQ-007 REQ: mem_stall SHALL be 1; dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL hold stable until ack or timeout.
REQ-008 REQ with dmem_ack=1 at an edge: the block SHALL clear dmem_req and go to DONE; on a read it SHALL load read_data_memory with dmem_rdata; on a write it SHALL leave read_data_memory unchanged.
REQ-009 REQ with dmem_ack=0: the 4-bit timeout counter SHALL increment each cycle.
REQ-010 When the counter equals TIMEOUT-1 and dmem_ack=0, the block SHALL at the next edge clear dmem_req, set read_data_memory=16'h0000 (reads only), set err_sticky=1 and go to DONE with a timeout flag.
REQ-011 If dmem_ack=1 and the timeout condition occur in the same cycle, ack SHALL win: normal completion, no error.
REQ-012 DONE: mem_stall=0 for exactly one cycle so the pipeline advances past the completed instruction; mem_error=1 only if entered by timeout; the next state SHALL be IDLE unconditionally.
REQ-013 DONE SHALL NOT re-evaluate access, so the just-completed instruction is never issued twice.
REQ-014 The block SHALL ignore dmem_ack in IDLE and DONE; a spurious ack SHALL change no output.
REQ-015 Minimum latency: an access first seen in cycle N SHALL have dmem_req=1 in N+1, ack no earlier than N+1, DONE in N+2, and mem_stall=1 in cycles N and N+1.
REQ-016 read_data_memory SHALL hold its value in all cycles that do not complete a read.

Reset
REQ-017 While reset=1 at an edge, the block SHALL enter IDLE and clear to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, read_data_memory, err_sticky and the counter.
REQ-018 With reset=1, mem_stall and mem_error SHALL be 0 in the following cycle.
REQ-019 Reset SHALL take priority over all other inputs, including an in-flight REQ with dmem_ack=1 in the same cycle; the aborted transaction is dropped.

Verification
REQ-020 The verification bench SHALL cover at least the following directed scenarios:
- Load: mem_read_r=1, addr_r=16'h0040; ack 3 cycles after req with rdata=16'hBEEF -> dmem_addr=16'h0040, dmem_we=0, stall for 4 cycles, read_data_memory=16'hBEEF in DONE.
- Store: mem_write_r=1, addr_r=16'h0012, store_data_r=16'h1234; ack on the first REQ cycle -> dmem_we=1, dmem_wdata=16'h1234, read_data_memory unchanged, DONE one cycle later.
- Timeout: load with no ack, TIMEOUT=15 -> 15 REQ cycles, then DONE with mem_error=1, read_data_memory=0, err_sticky=1 until reset.
- Back-to-back: load then store on consecutive instructions -> two separate transactions, exactly one DONE each, no duplicate request.
- Reset mid-REQ with simultaneous dmem_ack=1 -> IDLE, all outputs 0, read_data_memory not updated.
- Both reads and writes asserted, plus a spurious ack in IDLE -> the access is a write, and the ack has no effect.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage data-memory access controller: issues one request per load/store,
// stalls the pipeline until ack or timeout, and returns load data to MEM/WB.
module mem_access_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_r,
    input  logic        mem_write_r,
    input  logic [15:0] addr_r,
    input  logic [15:0] store_data_r,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [15:0] read_data_memory,
    output logic        mem_stall,
    output logic        mem_error,
    output logic        err_sticky
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic       access;
    logic [3:0] cnt;
    logic       timeout_flag;
    logic       timeout_hit;

    assign access      = mem_read_r | mem_write_r;
    assign timeout_hit = (state == REQ) && !dmem_ack && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        mem_error  = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    mem_stall  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (dmem_ack || timeout_hit) begin
                    state_next = DONE;
                end
            end
            // DONE never looks at access, so the finished instruction cannot reissue
            DONE: begin
                mem_error  = timeout_flag;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            mem_stall = 1'b0;
            mem_error = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= 16'h0000;
            dmem_wdata       <= 16'h0000;
            read_data_memory <= 16'h0000;
            err_sticky       <= 1'b0;
            cnt              <= 4'd0;
            timeout_flag     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        dmem_addr    <= addr_r;
                        dmem_wdata   <= store_data_r;
                        dmem_we      <= mem_write_r;
                        dmem_req     <= 1'b1;
                        cnt          <= 4'd0;
                        timeout_flag <= 1'b0;
                    end
                end
                // ack takes priority over a timeout landing in the same cycle
                REQ: begin
                    if (dmem_ack) begin
                        dmem_req     <= 1'b0;
                        timeout_flag <= 1'b0;
                        if (!dmem_we) begin
                            read_data_memory <= dmem_rdata;
                        end
                    end else if (cnt == CNT_LAST) begin
                        dmem_req     <= 1'b0;
                        err_sticky   <= 1'b1;
                        timeout_flag <= 1'b1;
                        if (!dmem_we) begin
                            read_data_memory <= 16'h0000;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: table of transactions checked through a scoreboard,
// plus hand-written spurious-ack and reset-during-request sequences.
module tb_mem_access_stage;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        reset;
    logic        mem_read_r;
    logic        mem_write_r;
    logic [15:0] addr_r;
    logic [15:0] store_data_r;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;
    logic [15:0] read_data_memory;
    logic        mem_stall;
    logic        mem_error;
    logic        err_sticky;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_read_r       (mem_read_r),
        .mem_write_r      (mem_write_r),
        .addr_r           (addr_r),
        .store_data_r     (store_data_r),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_ack         (dmem_ack),
        .read_data_memory (read_data_memory),
        .mem_stall        (mem_stall),
        .mem_error        (mem_error),
        .err_sticky       (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ack_cycle: REQ cycle (1-based) on which ack is given; 0 means never
    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          ack_cycle;
        logic [15:0] rdata;
        logic        exp_we;
        logic [15:0] exp_rdm;
        logic        exp_err;
        logic        exp_sticky;
        int          exp_stall;
    } vec_t;

    vec_t vecs [7];
    vec_t sb_q [$];

    int checks    = 0;
    int failures  = 0;
    int req_rises = 0;
    int exp_reqs  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: captures the request, checks stability, pops the scoreboard at DONE
    initial begin : monitor
        logic        prev_stall;
        logic        prev_req;
        int          stall_cnt;
        int          req_cnt;
        logic        cap_we;
        logic [15:0] cap_addr;
        logic [15:0] cap_wdata;
        vec_t        v;
        prev_stall = 1'b0;
        prev_req   = 1'b0;
        stall_cnt  = 0;
        req_cnt    = 0;
        cap_we     = 1'b0;
        cap_addr   = 16'h0;
        cap_wdata  = 16'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                prev_req   = 1'b0;
                stall_cnt  = 0;
                req_cnt    = 0;
            end else begin
                if (dmem_req && !prev_req) begin
                    req_rises++;
                    cap_we    = dmem_we;
                    cap_addr  = dmem_addr;
                    cap_wdata = dmem_wdata;
                end else if (dmem_req && prev_req) begin
                    chk("req_addr_stable", dmem_addr, cap_addr);
                end
                if (dmem_req) req_cnt++;
                if (mem_stall) stall_cnt++;
                if (prev_stall && !mem_stall) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        v = sb_q.pop_front();
                        chk("we",         cap_we, v.exp_we);
                        chk("addr",       cap_addr, v.addr);
                        chk("wdata",      cap_wdata, v.wdata);
                        chk("rdata_out",  read_data_memory, v.exp_rdm);
                        chk("mem_error",  mem_error, v.exp_err);
                        chk("err_sticky", err_sticky, v.exp_sticky);
                        chk("stall_cycles", stall_cnt, v.exp_stall);
                        chk("req_cycles", req_cnt, v.exp_stall - 1);
                        chk("req_done",   dmem_req, 0);
                    end
                    stall_cnt = 0;
                    req_cnt   = 0;
                end else begin
                    chk("mem_error_quiet", mem_error, 0);
                end
                prev_stall = mem_stall;
                prev_req   = dmem_req;
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Called #1 after a rising edge; returns #1 after the edge that ends DONE
    task automatic run_vec(input vec_t v);
        int k;
        mem_read_r   = v.rd;
        mem_write_r  = v.wr;
        addr_r       = v.addr;
        store_data_r = v.wdata;
        sb_q.push_back(v);
        exp_reqs++;
        @(posedge clk); #1;
        k = 1;
        forever begin
            dmem_ack   = (k == v.ack_cycle);
            dmem_rdata = dmem_ack ? v.rdata : 16'($urandom);
            @(posedge clk); #1;
            if (dmem_ack || k >= TIMEOUT) begin
                dmem_ack = 1'b0;
                break;
            end
            k++;
        end
        @(posedge clk); #1;
        mem_read_r   = 1'b0;
        mem_write_r  = 1'b0;
        addr_r       = 16'h0;
        store_data_r = 16'h0;
    endtask

    initial begin : stim
        //            rd    wr    addr      wdata     ack rdata     we    rdm       err   stk   stall
        vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 3,  16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 1'b0, 4};
        vecs[1] = '{1'b0, 1'b1, 16'h0012, 16'h1234, 1,  16'hDEAD, 1'b1, 16'hBEEF, 1'b0, 1'b0, 2};
        vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0F0F, 1,  16'h5A5A, 1'b0, 16'h5A5A, 1'b0, 1'b0, 2};
        vecs[3] = '{1'b1, 1'b1, 16'h0200, 16'hCAFE, 2,  16'h1111, 1'b1, 16'h5A5A, 1'b0, 1'b0, 3};
        vecs[4] = '{1'b1, 1'b0, 16'h0300, 16'h0000, 15, 16'h7777, 1'b0, 16'h7777, 1'b0, 1'b0, 16};
        vecs[5] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 0,  16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16};
        vecs[6] = '{1'b0, 1'b1, 16'h0055, 16'hAAAA, 1,  16'h3333, 1'b1, 16'h0000, 1'b0, 1'b1, 2};

        reset        = 1'b1;
        mem_read_r   = 1'b0;
        mem_write_r  = 1'b0;
        addr_r       = 16'h0;
        store_data_r = 16'h0;
        dmem_rdata   = 16'h0;
        dmem_ack     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   dmem_req, 0);
        chk("rst_we",    dmem_we, 0);
        chk("rst_addr",  dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_rdm",   read_data_memory, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_err",   mem_error, 0);
        chk("rst_stk",   err_sticky, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Vectors 0 and 1 run back-to-back: load then store with no idle gap
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Spurious ack in IDLE must change nothing
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hFFFF;
        @(negedge clk);
        chk("spur_stall", mem_stall, 0);
        chk("spur_req",   dmem_req, 0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("spur_rdm", read_data_memory, 16'h7777);
        chk("spur_req2", dmem_req, 0);
        @(posedge clk); #1;

        for (int i = 5; i < 7; i++) run_vec(vecs[i]);

        // Reset on a REQ cycle together with ack: transaction dropped
        mem_read_r = 1'b1;
        addr_r     = 16'h0777;
        exp_reqs++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 16'h9999;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("mid_rst_req",   dmem_req, 0);
        chk("mid_rst_we",    dmem_we, 0);
        chk("mid_rst_addr",  dmem_addr, 0);
        chk("mid_rst_wdata", dmem_wdata, 0);
        chk("mid_rst_rdm",   read_data_memory, 0);
        chk("mid_rst_stk",   err_sticky, 0);
        chk("mid_rst_stall", mem_stall, 0);
        chk("mid_rst_err",   mem_error, 0);
        @(posedge clk); #1;
        reset      = 1'b0;
        mem_read_r = 1'b0;
        addr_r     = 16'h0;
        @(negedge clk);
        chk("post_rst_stall", mem_stall, 0);
        chk("post_rst_rdm",   read_data_memory, 0);
        @(posedge clk); #1;

        chk("sb_empty",  sb_q.size(), 0);
        chk("req_count", req_rises, exp_reqs);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
